// File: rtl/shift_sequencer_pkg.sv
// Shared types and defaults for the multi-cycle shift sequencer.
package alu_shift_pkg;

  localparam int unsigned SHSEQ_WIDTH = 32;

  typedef enum logic [1:0] {
    SHOP_SRL = 2'b00,
    SHOP_SLL = 2'b01,
    SHOP_SRA = 2'b10,
    SHOP_ROR = 2'b11
  } shop_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle between ALU issue logic and the shift sequencer.
interface shift_sequencer_if
  import alu_shift_pkg::*;
#(
  parameter int unsigned WIDTH   = SHSEQ_WIDTH,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [SHAMT_W-1:0] in_movement;
  logic [1:0]         in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_result;
  logic               busy;

  modport master (
    output in_valid, in_a, in_movement, in_op, out_ready,
    input  in_ready, out_valid, out_result, busy
  );

  modport slave (
    input  in_valid, in_a, in_movement, in_op, out_ready,
    output in_ready, out_valid, out_result, busy
  );
endinterface

// File: rtl/shift_sequencer_stage.sv
// Combinational single logarithmic stage: shifts data by 2^stage_i, or passes it through.
module shift_stage
  import alu_shift_pkg::*;
#(
  parameter int unsigned WIDTH   = SHSEQ_WIDTH,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] stage_i,
  input  logic               en_i,
  input  shop_e              op_i,
  input  logic               sign_i,
  output logic [WIDTH-1:0]   data_o
);
  logic [31:0]      amt;
  logic [WIDTH-1:0] fill;

  always_comb begin
    amt    = 32'd1 << stage_i;
    fill   = '0;
    data_o = data_i;
    if (en_i) begin
      unique case (op_i)
        SHOP_SRL: data_o = data_i >> amt;
        SHOP_SLL: data_o = data_i << amt;
        SHOP_SRA: begin
          fill   = {WIDTH{sign_i}} << (WIDTH - amt);
          data_o = fill | (data_i >> amt);
        end
        SHOP_ROR: data_o = (data_i >> amt) | (data_i << (WIDTH - amt));
        default:  data_o = data_i;
      endcase
    end
  end
endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SRL/SLL/SRA/ROR controller applying one log stage per clock, MSB stage first.
// Optional macro SHIFT_SEQ_EARLY_EXIT_EN: leave SHIFT once no lower movement bits remain.
module shift_sequencer
  import alu_shift_pkg::*;
#(
  parameter int unsigned WIDTH   = SHSEQ_WIDTH,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             rst,
  shift_sequencer_if.slave bus
);
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] mov_q, mov_d;
  shop_e              op_q, op_d;
  logic               sign_q, sign_d;
  logic [SHAMT_W-1:0] stage_q, stage_d;
  logic [WIDTH-1:0]   stage_data;
  logic               early;

  shift_stage #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_stage (
    .data_i  (acc_q),
    .stage_i (stage_q),
    .en_i    (mov_q[stage_q]),
    .op_i    (op_q),
    .sign_i  (sign_q),
    .data_o  (stage_data)
  );

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  // A zero movement exits after the first (disabled) stage, giving one-cycle latency.
  logic [SHAMT_W-1:0] low_mask;
  always_comb begin
    low_mask = (SHAMT_W'(1) << stage_q) - SHAMT_W'(1);
    early    = (mov_q & low_mask) == '0;
  end
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mov_d   = mov_q;
    op_d    = op_q;
    sign_d  = sign_q;
    stage_d = stage_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d   = bus.in_a;
          mov_d   = bus.in_movement;
          op_d    = shop_e'(bus.in_op);
          sign_d  = bus.in_a[WIDTH-1];
          stage_d = SHAMT_W'(SHAMT_W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = stage_data;
        if (stage_q == '0 || early) state_d = DONE;
        else                        stage_d = stage_q - SHAMT_W'(1);
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mov_q   <= '0;
      op_q    <= SHOP_SRL;
      sign_q  <= 1'b0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mov_q   <= mov_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      stage_q <= stage_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.out_result = acc_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: results and latency predicted from whole-amount shifts.
module tb_shift_sequencer;
  localparam int unsigned W  = 32;
  localparam int unsigned SW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

  shift_sequencer #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [SW-1:0] mov);
    logic [2*W-1:0] dbl;
    dbl = {a, a} >> mov;
    case (op)
      2'b00:   return a >> mov;
      2'b01:   return a << mov;
      2'b10:   return W'($signed(a) >>> mov);
      default: return dbl[W-1:0];
    endcase
  endfunction

  function automatic int exp_latency(input logic [SW-1:0] mov);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    if (mov == '0) return 1;
    for (int i = 0; i < int'(SW); i++)
      if (mov[i]) return int'(SW) - i;
    return 1;
`else
    return int'(SW);
`endif
  endfunction

  // Issue one request, check latency, then consume and score the result with out_ready high.
  task automatic do_txn(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [SW-1:0] mov);
    int n;
    logic [W-1:0] exp;
    @(negedge clk);
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_a        = a;
    bus.in_movement = mov;
    bus.in_op       = op;
    exp_q.push_back(model(op, a, mov));
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.in_a        = $urandom;
    bus.in_movement = SW'($urandom);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != exp_latency(mov)) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, exp_latency(mov));
    end
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s done_flags: busy=%b in_ready=%b, expected busy=1 in_ready=0",
               name, bus.busy, bus.in_ready);
    end
    exp = exp_q.pop_front();
    checks++;
    if (bus.out_result !== exp) begin
      errors++;
      $display("FAIL %s result: got %h, expected %h", name, bus.out_result, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s return_idle: in_ready=%b out_valid=%b, expected 1/0",
               name, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.out_result !== '0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b result=%h, expected 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ops();
    do_txn("srl_msb_31", 2'b00, 32'h8000_0000, 5'd31);
    do_txn("sra_neg_4",  2'b10, 32'h8000_0000, 5'd4);
    do_txn("sra_pos_31", 2'b10, 32'h7FFF_FFFF, 5'd31);
    do_txn("sll_16",     2'b01, 32'h0000_0001, 5'd16);
    do_txn("ror_4",      2'b11, 32'h0000_000F, 5'd4);
  endtask

  task automatic test_boundaries();
    do_txn("srl_mov0",   2'b00, 32'hDEAD_BEEF, 5'd0);
    do_txn("ror_mov0",   2'b11, 32'h1234_5678, 5'd0);
    do_txn("sra_neg_31", 2'b10, 32'h8000_0001, 5'd31);
    do_txn("ror_31",     2'b11, 32'h8000_0001, 5'd31);
    do_txn("sll_31",     2'b01, 32'hFFFF_FFFF, 5'd31);
    do_txn("mov8",       2'b01, 32'h0000_00A5, 5'd8);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      do_txn("random", 2'($urandom), $urandom, SW'($urandom));
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held, exp;
    int n;
    @(negedge clk);
    bus.out_ready   = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_a        = 32'hC000_0003;
    bus.in_movement = 5'd3;
    bus.in_op       = 2'b11;
    exp_q.push_back(model(2'b11, 32'hC000_0003, 5'd3));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    held = bus.out_result;
    for (int c = 0; c < 3; c++) begin
      bus.in_valid    = 1'b1;
      bus.in_a        = $urandom;
      bus.in_movement = SW'($urandom);
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== held || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: out_valid=%b result=%h in_ready=%b, expected 1 %h 0",
                 bus.out_valid, bus.out_result, bus.in_ready, held);
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    exp = exp_q.pop_front();
    checks++;
    if (bus.out_result !== exp) begin
      errors++;
      $display("FAIL bp_result: got %h, expected %h", bus.out_result, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b, expected 1 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    @(negedge clk);
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_a        = 32'hFFFF_0000;
    bus.in_movement = 5'd7;
    bus.in_op       = 2'b00;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_result !== '0 ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: in_ready=%b out_valid=%b result=%h busy=%b, expected 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_result, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_abort: out_valid seen %0d cycles, expected 0", seen);
    end
    do_txn("after_rst", 2'b10, 32'h9000_0000, 5'd2);
  endtask

  task automatic test_back_to_back();
    int cyc, last_acc, gaps;
    logic [W-1:0] exp;
    last_acc = -1;
    gaps = 0;
    @(negedge clk);
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_a        = $urandom;
    bus.in_movement = SW'($urandom) | SW'(1);
    bus.in_op       = 2'($urandom);
    for (cyc = 0; cyc < 40; cyc++) begin
      if (bus.out_valid) begin
        exp = exp_q.pop_front();
        checks++;
        if (bus.out_result !== exp) begin
          errors++;
          $display("FAIL b2b_result: got %h, expected %h", bus.out_result, exp);
        end
      end
      if (bus.in_ready) begin
        exp_q.push_back(model(bus.in_op, bus.in_a, bus.in_movement));
        if (last_acc >= 0) begin
          gaps++;
          checks++;
          if (cyc - last_acc != int'(SW) + 2) begin
            errors++;
            $display("FAIL b2b_gap: got %0d cycles, expected %0d", cyc - last_acc, SW + 2);
          end
        end
        last_acc = cyc;
      end else begin
        bus.in_a        = $urandom;
        bus.in_movement = SW'($urandom) | SW'(1);
        bus.in_op       = 2'($urandom);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    for (int d = 0; d < 10 && exp_q.size() != 0; d++) begin
      if (bus.out_valid) begin
        exp = exp_q.pop_front();
        checks++;
        if (bus.out_result !== exp) begin
          errors++;
          $display("FAIL b2b_drain: got %h, expected %h", bus.out_result, exp);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0 || gaps < 3) begin
      errors++;
      $display("FAIL b2b_count: pending=%0d gaps=%0d, expected 0 pending and >=3 gaps",
               exp_q.size(), gaps);
    end
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_a        = '0;
    bus.in_movement = '0;
    bus.in_op       = 2'b00;
    bus.out_ready   = 1'b1;
    test_reset();
    test_ops();
    test_boundaries();
    test_random();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
